spi_radio_responder: RTL and testbench

SPI mode-0 slave that models the register/payload side of an nRF24L01+-style radio, answering the SoC's SPI master over `spi_sck/spi_ssn/spi_mosi/spi_miso`. It is synthesizable. It serves as the loopback partner for the SoC's SPI radio driver on hardware and as the SPI peer in system benches. A host-side push port fills its RX payload FIFO.

---
 rtl/spi_radio_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_radio_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_radio_responder.sv
// SPI mode-0 slave emulating the register and RX-payload side of an nRF24L01+-style
// radio; the host fills the payload FIFO through a valid/ready push port.
module spi_radio_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int NREGS      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_sck,
    input  logic               spi_ssn,
    input  logic               spi_mosi,
    output logic               spi_miso,
    input  logic               push_valid,
    input  logic [7:0]         push_data,
    output logic               push_ready,
    output logic               reg_wr_stb,
    output logic [4:0]         reg_wr_addr,
    output logic [7:0]         reg_wr_data,
    output logic [8*NREGS-1:0] regs_out,
    output logic               rx_dr
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] OP_RREG = 2'd0;
    localparam logic [1:0] OP_WREG = 2'd1;
    localparam logic [1:0] OP_RPAY = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    // Pin synchronizers; deliberately not reset so a select held across reset
    // is not mistaken for a fresh spi_ssn fall.
    logic [2:0] sck_sync_reg;
    logic [2:0] ssn_sync_reg;
    logic [1:0] mosi_sync_reg;

    always_ff @(posedge clk) begin
        sck_sync_reg  <= {sck_sync_reg[1:0], spi_sck};
        ssn_sync_reg  <= {ssn_sync_reg[1:0], spi_ssn};
        mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
    end

    logic sck_rise, sck_fall, ssn_fall, ssn_rise, mosi_bit;
    assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
    assign sck_fall = ~sck_sync_reg[1] & sck_sync_reg[2];
    assign ssn_fall = ~ssn_sync_reg[1] & ssn_sync_reg[2];
    assign ssn_rise = ssn_sync_reg[1] & ~ssn_sync_reg[2];
    assign mosi_bit = mosi_sync_reg[1];

    logic [1:0]    state_reg;
    logic [1:0]    op_reg;
    logic [4:0]    addr_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    rx_shift_reg;
    logic [7:0]    tx_shift_reg;
    logic          miso_reg;
    logic          fill_reg;
    logic          wr_pend_reg;
    logic [7:0]    wr_pend_data_reg;
    logic          stb_reg;
    logic [4:0]    wr_addr_reg;
    logic [7:0]    wr_data_reg;

    logic [7:0]    mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    rd_data_reg;

    logic [3:0]    count_lo;
    logic [7:0]    status_byte;
    logic [7:0]    reg_view [NREGS];

    assign count_lo    = 4'(count_reg);
    assign rx_dr       = (count_reg != '0);
    assign push_ready  = (count_reg != FULL_COUNT);
    assign status_byte = {1'b0, rx_dr, 2'b00, count_lo};

    // Register file: the last address is the live STATUS view, not storage.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS - 1; gi++) begin : g_reg
            logic [7:0] value_reg;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    value_reg <= 8'h00;
                else if (wr_pend_reg && addr_reg == 5'(gi))
                    value_reg <= wr_pend_data_reg;
            end
            assign reg_view[gi] = value_reg;
        end
        assign reg_view[NREGS-1] = status_byte;
        for (gi = 0; gi < NREGS; gi++) begin : g_out
            assign regs_out[8*gi +: 8] = reg_view[gi];
        end
    endgenerate

    logic [7:0] rx_byte;
    logic       byte_done;
    logic [1:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [1:0] eff_op;
    logic [4:0] eff_addr;
    logic [7:0] rd_byte;
    logic [7:0] load_byte;
    logic       push_ok;
    logic       pop_ok;
    logic       wr_ok;

    assign rx_byte   = {rx_shift_reg[6:0], mosi_bit};
    assign byte_done = sck_rise && !ssn_rise && (state_reg != ST_IDLE) && (bit_cnt_reg == 3'd7);

    always_comb begin
        cmd_op   = OP_NOP;
        cmd_addr = rx_byte[4:0];
        if (rx_byte[7:5] == 3'b000)
            cmd_op = OP_RREG;
        else if (rx_byte[7:5] == 3'b001)
            cmd_op = OP_WREG;
        else if (rx_byte == 8'h61)
            cmd_op = OP_RPAY;
    end

    // At the command boundary the freshly decoded opcode selects the first data byte.
    assign eff_op   = (state_reg == ST_CMD) ? cmd_op : op_reg;
    assign eff_addr = (state_reg == ST_CMD) ? cmd_addr : addr_reg;

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (eff_addr == 5'(i))
                rd_byte = reg_view[i];
        end
    end

    assign load_byte = (eff_op == OP_RREG) ? rd_byte : 8'h00;
    assign push_ok   = push_valid && push_ready;
    assign pop_ok    = byte_done && (eff_op == OP_RPAY) && (count_reg != '0);
    assign wr_ok     = byte_done && (state_reg == ST_DATA) && (op_reg == OP_WREG)
                       && (int'(addr_reg) < NREGS - 1);

    // Payload storage with registered read; the popped byte reaches the shifter one cycle later.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= push_data;
        rd_data_reg <= mem_reg[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_pend_reg      <= 1'b0;
            wr_pend_data_reg <= 8'h00;
            stb_reg          <= 1'b0;
            wr_addr_reg      <= 5'd0;
            wr_data_reg      <= 8'h00;
        end else begin
            wr_pend_reg <= wr_ok;
            if (wr_ok)
                wr_pend_data_reg <= rx_byte;
            stb_reg <= wr_pend_reg;
            if (wr_pend_reg) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= wr_pend_data_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NOP;
            addr_reg     <= 5'd0;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 8'h00;
            tx_shift_reg <= 8'h00;
            miso_reg     <= 1'b0;
            fill_reg     <= 1'b0;
        end else begin
            fill_reg <= 1'b0;
            if (fill_reg)
                tx_shift_reg <= rd_data_reg;
            if (state_reg != ST_IDLE && ssn_rise) begin
                state_reg <= ST_IDLE;
                miso_reg  <= 1'b0;
            end else if (state_reg == ST_IDLE) begin
                if (ssn_fall) begin
                    state_reg    <= ST_CMD;
                    bit_cnt_reg  <= 3'd0;
                    tx_shift_reg <= {status_byte[6:0], 1'b0};
                    miso_reg     <= status_byte[7];
                end
            end else if (sck_rise) begin
                rx_shift_reg <= rx_byte;
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    tx_shift_reg <= load_byte;
                    fill_reg     <= pop_ok;
                    if (state_reg == ST_CMD) begin
                        state_reg <= ST_DATA;
                        op_reg    <= cmd_op;
                        addr_reg  <= cmd_addr;
                    end
                end
            end else if (sck_fall) begin
                miso_reg     <= tx_shift_reg[7];
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
        end
    end

    assign spi_miso    = miso_reg;
    assign reg_wr_stb  = stb_reg;
    assign reg_wr_addr = wr_addr_reg;
    assign reg_wr_data = wr_data_reg;
endmodule

// File: tb/tb_spi_radio_responder.sv
// Randomized bench for spi_radio_responder: an SPI master plus a queue/array
// model of registers, payload FIFO and write strobes.
module tb_spi_radio_responder;
    localparam int FD = 8;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          spi_sck;
    logic          spi_ssn;
    logic          spi_mosi;
    logic          spi_miso;
    logic          push_valid;
    logic [7:0]    push_data;
    logic          push_ready;
    logic          reg_wr_stb;
    logic [4:0]    reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic [8*NR-1:0] regs_out;
    logic          rx_dr;

    spi_radio_responder #(.FIFO_DEPTH(FD), .NREGS(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_ssn     (spi_ssn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .regs_out    (regs_out),
        .rx_dr       (rx_dr)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_regs [NR-1];
    logic [7:0]  m_fifo [$];
    logic [12:0] exp_stb_q [$];
    logic [12:0] stb_q [$];
    logic [7:0]  tx_buf [16];
    logic [7:0]  exp_rx [16];

    always @(negedge clk) begin
        if (rst_n && reg_wr_stb)
            stb_q.push_back({reg_wr_addr, reg_wr_data});
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int sz = m_fifo.size();
        return {1'b0, sz != 0, 2'b00, 4'(sz)};
    endfunction

    function automatic logic [63:0] m_regs_vec();
        logic [63:0] v;
        for (int i = 0; i < NR - 1; i++) v[8*i +: 8] = m_regs[i];
        v[63:56] = m_status();
        return v;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_stb_q.delete();
        for (int i = 0; i < NR - 1; i++) m_regs[i] = 8'h00;
    endtask

    // Transfers nb bits MSB first; MISO is captured just before each SCK rise.
    task automatic spi_bits(input logic [7:0] d, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = d[i];
            repeat (3) @(negedge clk);
            r[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (6) @(negedge clk);
            spi_sck = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        push_valid = 1'b1;
        push_data  = d;
        check_val("push_ready", push_ready, m_fifo.size() < FD);
        if (m_fifo.size() < FD) m_fifo.push_back(d);
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic check_side(input string tag);
        check_val({tag, "_stb_n"}, stb_q.size(), exp_stb_q.size());
        while (stb_q.size() > 0 && exp_stb_q.size() > 0)
            check_val({tag, "_stb"}, stb_q.pop_front(), exp_stb_q.pop_front());
        stb_q.delete();
        exp_stb_q.delete();
        check_val({tag, "_ready"}, push_ready, m_fifo.size() < FD);
        check_val({tag, "_rx_dr"}, rx_dr, m_fifo.size() != 0);
        check_val({tag, "_regs"}, regs_out, m_regs_vec());
    endtask

    // One full transaction of n bytes from tx_buf; the model predicts every MISO byte.
    task automatic run_txn(input int n);
        logic [7:0] cmd;
        logic [7:0] r;
        int a;
        cmd = tx_buf[0];
        a = int'(cmd[4:0]);
        exp_rx[0] = m_status();
        for (int k = 1; k <= n; k++) begin
            logic [7:0] v;
            v = 8'h00;
            if (cmd[7:5] == 3'b000)
                v = (a < NR - 1) ? m_regs[a] : ((a == NR - 1) ? m_status() : 8'h00);
            else if (cmd == 8'h61 && m_fifo.size() > 0)
                v = m_fifo.pop_front();
            if (k < n) exp_rx[k] = v;
        end
        if (cmd[7:5] == 3'b001 && a < NR - 1) begin
            for (int k = 1; k < n; k++) begin
                m_regs[a] = tx_buf[k];
                exp_stb_q.push_back({5'(a), tx_buf[k]});
            end
        end
        spi_ssn = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            spi_bits(tx_buf[k], 8, r);
            check_val($sformatf("cmd%02h_rx%0d", cmd, k), r, exp_rx[k]);
        end
        spi_ssn = 1'b1;
        repeat (6) @(negedge clk);
        check_side($sformatf("cmd%02h", cmd));
        $display("txn cmd=%02h bytes=%0d fifo=%0d", cmd, n, m_fifo.size());
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0; spi_sck = 1'b0; spi_ssn = 1'b1; spi_mosi = 1'b0;
        push_valid = 1'b0; push_data = 8'h00;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_miso", spi_miso, 1'b0);
        check_val("rst_stb", reg_wr_stb, 1'b0);
        check_val("rst_addr", reg_wr_addr, 5'd0);
        check_val("rst_data", reg_wr_data, 8'h00);
        check_side("rst");

        tx_buf[0] = 8'hFF;
        run_txn(1);

        // Register write then read back, including the STATUS byte
        tx_buf[0] = 8'h23; tx_buf[1] = 8'hA5;
        run_txn(2);
        tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        run_txn(3);

        // Payload drain with underflow
        push_one(8'h68); push_one(8'h6F); push_one(8'h6C);
        tx_buf[0] = 8'h61;
        for (int i = 1; i < 5; i++) tx_buf[i] = 8'h00;
        run_txn(5);

        // FIFO full: nine back-to-back pushes, the ninth is dropped
        for (int i = 1; i <= 9; i++) push_one(8'(i));
        tx_buf[0] = 8'hFF;
        run_txn(1);
        tx_buf[0] = 8'h61;
        for (int i = 1; i < 10; i++) tx_buf[i] = 8'h00;
        run_txn(10);

        // Abort mid-byte during a write
        tx_buf[0] = 8'h21; tx_buf[1] = 8'h5A;
        run_txn(2);
        spi_ssn = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'h21, 8, r);
        check_val("abort_status", r, m_status());
        spi_bits(8'hFF, 5, r);
        spi_ssn = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_miso", spi_miso, 1'b0);
        repeat (3) @(negedge clk);
        check_side("abort_w");

        // Abort mid-byte while reading a register whose bits are non-zero
        spi_ssn = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'h01, 8, r);
        spi_bits(8'h00, 3, r);
        check_val("abort_rd_bits", r, 8'h40);
        spi_ssn = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_rd_miso", spi_miso, 1'b0);
        repeat (3) @(negedge clk);
        check_side("abort_r");

        // Reset in the middle of a payload read
        push_one(8'hC3); push_one(8'h3C);
        spi_ssn = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'h61, 8, r);
        check_val("rstmid_status", r, 8'h42);
        spi_bits(8'h00, 3, r);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        spi_ssn = 1'b1;
        repeat (6) @(negedge clk);
        stb_q.delete();
        check_side("rstmid");
        tx_buf[0] = 8'hFF;
        run_txn(1);

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            int np, kind, n;
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) push_one(8'($urandom));
            kind = $urandom_range(0, 3);
            case (kind)
                0:       tx_buf[0] = {3'b000, 5'($urandom_range(0, 9))};
                1:       tx_buf[0] = {3'b001, 5'($urandom_range(0, 9))};
                2:       tx_buf[0] = 8'h61;
                default: tx_buf[0] = 8'($urandom);
            endcase
            n = $urandom_range(1, 5);
            for (int i = 1; i < n; i++) tx_buf[i] = 8'($urandom);
            run_txn(n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
